// File: rtl/ysyx_25060170_pipe_skid_pkg.sv
// ysyx_25060170_pipe_skid_pkg
//   Shared constants for the generic pipeline-stage register.
//   - RST_LEVEL : level of the reset input that holds the block in reset.
//   - ST_*      : occupancy-state encodings; the encoding equals the number
//                 of entries held, so it is driven straight onto occ.
//   - rst_active: helper turning the raw reset pin into an "in reset" flag.
package ysyx_25060170_pipe_skid_pkg;

  localparam logic RST_LEVEL = 1'b0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic logic rst_active(input logic rst);
    return rst == RST_LEVEL;
  endfunction

endpackage

// File: rtl/ysyx_25060170_sat_cnt.sv
// ysyx_25060170_sat_cnt
//   Saturating up-counter that adds 0..3 per cycle and sticks at all-ones.
//   Ports:
//     clk  in          : clock
//     clr  in          : synchronous clear (wins over inc)
//     inc  in  [1:0]   : amount to add this cycle
//     cnt  out [CNT_W] : current count
module ysyx_25060170_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  // One extra bit catches the carry that means "past all-ones".
  logic [CNT_W:0] sum;

  always_comb begin
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
  end

  // NOTE: non-blocking assignments keep every flop updating from the
  // pre-edge values, so ordering between sequential blocks cannot matter.
  always_ff @(posedge clk) begin
    if (clr)              cnt <= '0;
    else if (sum[CNT_W])  cnt <= '1;
    else                  cnt <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/ysyx_25060170_pipe_skid.sv
// ysyx_25060170_pipe_skid
//   Generic pipeline-stage register with valid/ready handshake, optional
//   two-entry skid buffer and multi-source flush.
//   Parameters: W payload width, SKID (1 = registered in_ready, 2 entries;
//   0 = single entry), NFLUSH flush lines, CNT_W drop-counter width.
//   Ports:
//     clk, rst (synchronous, active-low)
//     in_valid/in_ready/in_data    : upstream handshake and payload
//     out_valid/out_ready/out_data : downstream handshake and head payload
//     flush [NFLUSH]               : flush requests, any one empties the stage
//     occ   [2]                    : entries held (0..2)
//     drop_cnt [CNT_W]             : saturating count of entries flushed
module ysyx_25060170_pipe_skid
  import ysyx_25060170_pipe_skid_pkg::*;
#(
  parameter int W      = 32,
  parameter int SKID   = 1,
  parameter int NFLUSH = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  input  logic [NFLUSH-1:0] flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [1:0]   state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_rst;
  logic         flush_any;
  logic         push;
  logic         pop;

  assign in_rst    = rst_active(rst);
  assign flush_any = |flush;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state;

  // In skid mode in_ready is a function of registered state only, which
  // breaks the out_ready -> in_ready combinational path between stages.
  always_comb begin
    if (SKID != 0) in_ready = !in_rst && !flush_any && (state != ST_TWO);
    else           in_ready = !in_rst && !flush_any && (!out_valid || out_ready);
  end

  assign push = in_valid && in_ready;
  // A flush swallows a same-cycle pop: the entry is dropped, not delivered.
  assign pop  = out_valid && out_ready && !flush_any;

  // NOTE: payload registers are reset (and zeroed on flush) so a squashed
  // stage never exposes stale data on out_data.
  always_ff @(posedge clk) begin
    if (in_rst || flush_any) begin
      state  <= ST_EMPTY;
      main_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state  <= ST_ONE;
            main_q <= in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push) begin
            // Only reachable with a skid slot; without one push implies pop.
            if (SKID != 0) state <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state  <= ST_ONE;
            main_q <= skid_q;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk) begin
        if (in_rst || flush_any)                     skid_q <= '0;
        else if (push && !pop && state == ST_ONE)    skid_q <= in_data;
      end
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  // Reset clears the counter; a flush adds however many entries it discards.
  ysyx_25060170_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk (clk),
    .clr (in_rst),
    .inc (flush_any ? state : 2'd0),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_ysyx_25060170_pipe_skid.sv
// Bench for ysyx_25060170_pipe_skid: a skid-mode instance (CNT_W=2 so the
// drop counter saturates quickly) and a pass-through instance. Stimulus
// pushes expected payloads into per-instance queues; monitors pop and
// compare whenever the DUT transfers an output.
module tb_ysyx_25060170_pipe_skid;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Skid-mode instance
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [31:0] in_data1 = '0, out_data1;
  logic [2:0]  flush1 = '0;
  logic [1:0]  occ1, drop_cnt1;

  // Pass-through instance
  logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
  logic [31:0] in_data0 = '0, out_data0;
  logic [2:0]  flush0 = '0;
  logic [1:0]  occ0;
  logic [15:0] drop_cnt0;

  ysyx_25060170_pipe_skid #(.W(32), .SKID(1), .NFLUSH(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .flush(flush1), .occ(occ1), .drop_cnt(drop_cnt1));

  ysyx_25060170_pipe_skid #(.W(32), .SKID(0), .NFLUSH(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .flush(flush0), .occ(occ0), .drop_cnt(drop_cnt0));

  int n_checks = 0;
  int n_pass   = 0;
  int pops1    = 0;
  int pops0    = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitors: a transfer is out_valid & out_ready outside reset and flush.
  always @(negedge clk) begin
    if (rst && out_valid1 && out_ready1 && flush1 == '0) begin
      check("pop1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        check("pop1_data", out_data1, q1.pop_front());
        pops1++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid0 && out_ready0 && flush0 == '0) begin
      check("pop0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        check("pop0_data", out_data0, q0.pop_front());
        pops0++;
      end
    end
  end

  // One cycle on the skid instance: drive, check in_ready/occ mid-cycle,
  // record the expected payload if this cycle should be a push.
  task automatic cyc1(input string nm, input logic iv, input logic [31:0] d,
                      input logic ordy, input logic [2:0] fl,
                      input logic exp_ir, input logic [1:0] exp_occ);
    in_valid1 = iv; in_data1 = d; out_ready1 = ordy; flush1 = fl;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready1), 32'(exp_ir));
    check({nm, "_occ"}, 32'(occ1), 32'(exp_occ));
    if (iv && exp_ir) q1.push_back(d);
    if (fl != '0) q1.delete();
    @(posedge clk); #1;
  endtask

  task automatic cyc0(input string nm, input logic iv, input logic [31:0] d,
                      input logic ordy, input logic exp_ir, input logic [1:0] exp_occ);
    in_valid0 = iv; in_data0 = d; out_ready0 = ordy;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready0), 32'(exp_ir));
    check({nm, "_occ"}, 32'(occ0), 32'(exp_occ));
    if (iv && exp_ir) q0.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = '0;
    @(negedge clk);
    check({nm, "_in_ready_in_reset"}, 32'(in_ready1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_occ"}, 32'(occ1), 32'd0);
    check({nm, "_out_valid"}, 32'(out_valid1), 32'd0);
    check({nm, "_drop_cnt"}, 32'(drop_cnt1), 32'd0);
    q1.delete();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values after the first reset edge
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready1), 32'd0);
    check("rst_out_valid", 32'(out_valid1), 32'd0);
    check("rst_out_data", out_data1, 32'd0);
    check("rst_occ", 32'(occ1), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt1), 32'd0);
    check("rst_in_ready0", 32'(in_ready0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Streaming with out_ready held high
    cyc1("s1", 1'b1, 32'h11, 1'b1, 3'b000, 1'b1, 2'd0);
    cyc1("s2", 1'b1, 32'h22, 1'b1, 3'b000, 1'b1, 2'd1);
    cyc1("s3", 1'b1, 32'h33, 1'b1, 3'b000, 1'b1, 2'd1);
    cyc1("s4", 1'b0, 32'h0,  1'b1, 3'b000, 1'b1, 2'd1);
    cyc1("s5", 1'b0, 32'h0,  1'b1, 3'b000, 1'b1, 2'd0);

    // Back-pressure: two accepted, third held off until after first pop
    cyc1("b1", 1'b1, 32'hA, 1'b0, 3'b000, 1'b1, 2'd0);
    cyc1("b2", 1'b1, 32'hB, 1'b0, 3'b000, 1'b1, 2'd1);
    cyc1("b3", 1'b1, 32'hC, 1'b0, 3'b000, 1'b0, 2'd2);
    cyc1("b4", 1'b1, 32'hC, 1'b1, 3'b000, 1'b0, 2'd2);
    cyc1("b5", 1'b1, 32'hC, 1'b1, 3'b000, 1'b1, 2'd1);
    cyc1("b6", 1'b0, 32'h0, 1'b1, 3'b000, 1'b1, 2'd1);
    cyc1("b7", 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 2'd0);
    check("b_out_valid_idle", 32'(out_valid1), 32'd0);

    // Flush when full, with a payload on offer
    cyc1("f1", 1'b1, 32'hD, 1'b0, 3'b000, 1'b1, 2'd0);
    cyc1("f2", 1'b1, 32'hE, 1'b0, 3'b000, 1'b1, 2'd1);
    cyc1("f3", 1'b1, 32'hF, 1'b0, 3'b010, 1'b0, 2'd2);
    check("f_out_valid", 32'(out_valid1), 32'd0);
    check("f_out_data", out_data1, 32'd0);
    check("f_drop_cnt", 32'(drop_cnt1), 32'd2);
    cyc1("f4", 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 2'd0);

    // Flush coinciding with a pop: dropped, not delivered
    cyc1("g1", 1'b1, 32'h55, 1'b0, 3'b000, 1'b1, 2'd0);
    cyc1("g2", 1'b0, 32'h0,  1'b1, 3'b001, 1'b0, 2'd1);
    check("g_drop_cnt", 32'(drop_cnt1), 32'd3);
    cyc1("g3", 1'b0, 32'h0,  1'b1, 3'b000, 1'b1, 2'd0);
    check("g_out_valid", 32'(out_valid1), 32'd0);

    // Saturation of the 2-bit drop counter
    do_reset("r1");
    for (int k = 0; k < 4; k++) begin
      cyc1("sat_p1", 1'b1, 32'h100 + 32'(k), 1'b0, 3'b000, 1'b1, 2'd0);
      cyc1("sat_p2", 1'b1, 32'h200 + 32'(k), 1'b0, 3'b000, 1'b1, 2'd1);
      cyc1("sat_fl", 1'b0, 32'h0,            1'b0, 3'b100, 1'b0, 2'd2);
      check("sat_drop_cnt", 32'(drop_cnt1), (k == 0) ? 32'd2 : 32'd3);
    end

    // Reset mid-stream while holding two entries
    cyc1("m1", 1'b1, 32'h71, 1'b0, 3'b000, 1'b1, 2'd0);
    cyc1("m2", 1'b1, 32'h72, 1'b0, 3'b000, 1'b1, 2'd1);
    do_reset("r2");
    cyc1("m3", 1'b0, 32'h0, 1'b0, 3'b000, 1'b1, 2'd0);

    // Pass-through instance: out_ready toggles with continuous in_valid
    cyc0("p1", 1'b1, 32'h61, 1'b1, 1'b1, 2'd0);
    cyc0("p2", 1'b1, 32'h62, 1'b0, 1'b0, 2'd1);
    cyc0("p3", 1'b1, 32'h62, 1'b1, 1'b1, 2'd1);
    cyc0("p4", 1'b1, 32'h63, 1'b0, 1'b0, 2'd1);
    cyc0("p5", 1'b1, 32'h63, 1'b1, 1'b1, 2'd1);
    cyc0("p6", 1'b0, 32'h0,  1'b1, 1'b1, 2'd1);
    cyc0("p7", 1'b0, 32'h0,  1'b0, 1'b1, 2'd0);

    check("pops1_total", 32'(pops1), 32'd6);
    check("pops0_total", 32'(pops0), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
